// File: rtl/seg_rw_seq.sv
// Block-transfer initiator for a segment memory: one command in, a stream of
// addr/dataW/write request tokens out, read data returned in order.
module seg_rw_seq #(
  parameter int NELEMS  = 127,
  parameter int DWIDTH  = 127,
  parameter int AWIDTH  = 7,
  parameter int LWIDTH  = 8,
  parameter int MAX_OUT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_base,
  input  logic [LWIDTH-1:0] cmd_len,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [AWIDTH-1:0] seg_addr,
  output logic [DWIDTH-1:0] seg_dataW,
  output logic              seg_write,
  output logic              seg_req_valid,
  input  logic              seg_req_ready,
  input  logic [DWIDTH-1:0] seg_dataR,
  input  logic              seg_rsp_valid,
  output logic              seg_rsp_ready,
  output logic              done,
  output logic              err
);

  localparam int OW = 4;
  localparam logic [AWIDTH:0]   NEL  = (AWIDTH+1)'(NELEMS);
  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(NELEMS - 1);
  localparam logic [OW-1:0]     MAXO = OW'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d, addr_nxt;
  logic [LWIDTH-1:0] rem_q, rem_d;
  logic [OW-1:0]     out_q, out_d;
  logic              write_q, write_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rsp_active, req_hs, rsp_hs, rd_inc;

  assign addr_nxt = (addr_q == LAST) ? '0 : addr_q + AWIDTH'(1);

  // Response path is live only mid-transfer and never during reset.
  assign rsp_active    = (state_q != IDLE) & ~reset;
  assign rd_data       = seg_dataR;
  assign rd_valid      = seg_rsp_valid & rsp_active;
  assign seg_rsp_ready = rd_ready & rsp_active;
  assign rsp_hs        = rd_valid & rd_ready;

  assign cmd_ready = (state_q == IDLE);
  assign seg_addr  = addr_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    seg_req_valid = 1'b0;
    seg_write     = 1'b0;
    seg_dataW     = '0;
    wr_ready      = 1'b0;
    if (state_q == ISSUE) begin
      if (write_q) begin
        seg_req_valid = wr_valid;
        seg_write     = 1'b1;
        seg_dataW     = wr_data;
        wr_ready      = seg_req_ready;
      end else begin
        seg_req_valid = (out_q < MAXO);
      end
    end
  end

  assign req_hs = seg_req_valid & seg_req_ready;
  assign rd_inc = req_hs & ~write_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    write_d = write_q;
    err_d   = err_q;
    done_d  = 1'b0;
    out_d   = out_q;
    unique case ({rd_inc, rsp_hs})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          if ({1'b0, cmd_base} >= NEL) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else if (cmd_len == '0) begin
            err_d  = 1'b0;
            done_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            addr_d  = cmd_base;
            rem_d   = cmd_len;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (req_hs) begin
          addr_d = addr_nxt;
          rem_d  = rem_q - LWIDTH'(1);
          if (rem_q == LWIDTH'(1)) begin
            if (write_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (rsp_hs && out_q == OW'(1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      write_q <= write_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_seg_rw_seq.sv
// Directed bench for seg_rw_seq: scoreboarded request/response streams
// against a small segment model with controllable response release.
module tb_seg_rw_seq;

  localparam int NELEMS  = 127;
  localparam int DWIDTH  = 127;
  localparam int AWIDTH  = 7;
  localparam int LWIDTH  = 8;
  localparam int MAX_OUT = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [AWIDTH-1:0] cmd_base;
  logic [LWIDTH-1:0] cmd_len;
  logic [DWIDTH-1:0] wr_data, rd_data, seg_dataW, seg_dataR;
  logic              wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AWIDTH-1:0] seg_addr;
  logic              seg_write, seg_req_valid, seg_req_ready;
  logic              seg_rsp_valid, seg_rsp_ready, done, err;

  seg_rw_seq #(
    .NELEMS(NELEMS), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH),
    .LWIDTH(LWIDTH), .MAX_OUT(MAX_OUT)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .seg_addr(seg_addr), .seg_dataW(seg_dataW), .seg_write(seg_write),
    .seg_req_valid(seg_req_valid), .seg_req_ready(seg_req_ready),
    .seg_dataR(seg_dataR), .seg_rsp_valid(seg_rsp_valid),
    .seg_rsp_ready(seg_rsp_ready), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, cmd_cyc = 0, last_req = -1, last_rsp = -1;
  int done_cyc = -1, done_cnt = 0, n_req = 0, out_cnt = 0, r0 = 0;
  bit rsp_en = 1'b1, wr_en = 1'b1, req_tog = 1'b0, busy_w = 1'b0;

  int unsigned       exp_addr[$];
  bit                exp_w[$];
  logic [DWIDTH-1:0] exp_dw[$], wq[$], pend[$], exp_rd[$];

  function automatic logic [DWIDTH-1:0] rdat(input int unsigned a);
    return DWIDTH'(a) * DWIDTH'(65537) + DWIDTH'(7);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int unsigned       ea;
    bit                ew;
    logic [DWIDTH-1:0] ed;
    seg_rsp_valid = rsp_en && pend.size() > 0;
    seg_dataR     = seg_rsp_valid ? pend[0] : '0;
    wr_valid      = wr_en && wq.size() > 0;
    wr_data       = wr_valid ? wq[0] : '0;
    seg_req_ready = req_tog ? cyc[0] : 1'b1;
    #1;
    if (busy_w) chk("wr_ready_pass", wr_ready, seg_req_ready);
    if (seg_req_valid && seg_req_ready) begin
      if (exp_addr.size() == 0) begin
        chk("unexpected_req", 1, 0);
      end else begin
        ea = exp_addr.pop_front();
        ew = exp_w.pop_front();
        ed = exp_dw.pop_front();
        chk("req_addr", seg_addr, ea);
        chk("req_write", seg_write, ew);
        chk("req_dataW", seg_dataW, ed);
        if (ew) begin
          chk("wr_ready_hs", wr_ready, 1);
          if (wq.size() > 0) void'(wq.pop_front());
          if (exp_addr.size() == 0) busy_w = 1'b0;
        end else begin
          pend.push_back(rdat(seg_addr));
          exp_rd.push_back(rdat(ea));
          out_cnt++;
          chk("out_bound", out_cnt <= MAX_OUT, 1);
        end
      end
      last_req = cyc;
      n_req++;
    end
    if (rd_valid && rd_ready) begin
      if (exp_rd.size() == 0) chk("unexpected_rd", 1, 0);
      else chk("rd_data", rd_data, exp_rd.pop_front());
      chk("rsp_ready", seg_rsp_ready, 1);
      if (pend.size() > 0) void'(pend.pop_front());
      out_cnt--;
      last_rsp = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic send_cmd(input bit w, input int base, input int len,
                          input int start);
    int unsigned a;
    logic [DWIDTH-1:0] d;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_base  = AWIDTH'(base);
    cmd_len   = LWIDTH'(len);
    if (base < NELEMS) begin
      a = base;
      for (int i = 0; i < len; i++) begin
        d = w ? DWIDTH'(start + i) : '0;
        exp_addr.push_back(a);
        exp_w.push_back(w);
        exp_dw.push_back(d);
        if (w) wq.push_back(d);
        a = (a == NELEMS - 1) ? 0 : a + 1;
      end
    end
    #1;
    chk("cmd_ready", cmd_ready, 1);
    cmd_cyc = cyc;
    cycle();
    cmd_valid = 1'b0;
    if (w && base < NELEMS && len > 0) busy_w = 1'b1;
  endtask

  task automatic run_done(input string tag, input int limit);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < limit && done_cnt == d0; i++) cycle();
    chk(tag, done_cnt - d0, 1);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b1;
    seg_req_ready = 1'b1; seg_dataR = '1; seg_rsp_valid = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_req_valid", seg_req_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rsp_ready", seg_rsp_ready, 0);
    reset = 1'b0;
    seg_rsp_valid = 1'b0;
    cycle();
    chk("idle_rsp_ready", seg_rsp_ready, 0);

    // write burst
    send_cmd(1'b1, 5, 3, 'hA);
    run_done("wr_done", 20);
    chk("wr_done_lat", done_cyc, last_req + 1);
    chk("wr_err", err, 0);
    chk("wr_drained", exp_addr.size(), 0);

    // read with responses withheld
    rsp_en = 1'b0;
    r0 = n_req;
    send_cmd(1'b0, 0, 8, 0);
    repeat (8) cycle();
    chk("bp_reqs", n_req - r0, MAX_OUT);
    chk("bp_stall", seg_req_valid, 0);
    rsp_en = 1'b1;
    run_done("bp_done", 60);
    chk("bp_done_lat", done_cyc, last_rsp + 1);
    chk("bp_rd_all", exp_rd.size(), 0);

    // responses one cycle behind requests: overlap keeps full rate
    send_cmd(1'b0, 30, 8, 0);
    run_done("ov_done", 40);
    chk("ov_latency", done_cyc - cmd_cyc, 10);
    chk("ov_out_zero", out_cnt, 0);

    // address wrap
    send_cmd(1'b0, 125, 4, 0);
    run_done("wrap_done", 30);
    chk("wrap_drained", exp_addr.size(), 0);

    // zero length
    send_cmd(1'b1, 3, 0, 0);
    run_done("len0_done", 5);
    chk("len0_lat", done_cyc, cmd_cyc + 1);
    chk("len0_err", err, 0);

    // base out of range
    send_cmd(1'b0, 127, 5, 0);
    run_done("bad_done", 5);
    chk("bad_lat", done_cyc, cmd_cyc + 1);
    chk("bad_err", err, 1);

    // valid write under toggling seg_req_ready clears err
    req_tog = 1'b1;
    send_cmd(1'b1, 40, 2, 'h55);
    run_done("clr_done", 20);
    chk("clr_err", err, 0);
    req_tog = 1'b0;

    // reset with reads outstanding
    rsp_en = 1'b0;
    r0 = n_req;
    send_cmd(1'b0, 20, 6, 0);
    repeat (3) cycle();
    chk("mid_reqs", n_req - r0, 3);
    reset = 1'b1;
    seg_rsp_valid = 1'b1;
    #1;
    chk("mid_cmd_ready", cmd_ready, 1);
    chk("mid_req_valid", seg_req_valid, 0);
    chk("mid_rd_valid", rd_valid, 0);
    chk("mid_done", done, 0);
    chk("mid_wr_ready", wr_ready, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    seg_rsp_valid = 1'b0;
    exp_addr.delete(); exp_w.delete(); exp_dw.delete();
    wq.delete(); pend.delete(); exp_rd.delete();
    out_cnt = 0;
    busy_w = 1'b0;
    rsp_en = 1'b1;
    r0 = n_req;
    send_cmd(1'b0, 10, 1, 0);
    run_done("post_done", 20);
    chk("post_reqs", n_req - r0, 1);
    chk("post_lat", done_cyc, last_rsp + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_rw_seq.md
Name: seg_rw_seq

Overview:
- Initiator for the segment read/write operator: turns one block-transfer command (base, length, direction) into a stream of addr/dataW/write tokens on the segment request channel.
- Returns read data in order on an output stream.
- Sits between a host-side streaming operator and a segment memory, on the side opposite the segment datapath.
- Tracks outstanding reads, wraps addresses modulo the segment size, and signals completion.

Parameters:
- NELEMS, 127, number of words in the target segment.
- DWIDTH, 127, data word width.
- AWIDTH, 7, address width; NELEMS must not exceed 2^AWIDTH.
- LWIDTH, 8, transfer-length width.
- MAX_OUT, 4, maximum outstanding read requests (1..15).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write transfer, 0 = read transfer.
- cmd_base  in  AWIDTH  first segment address.
- cmd_len  in  LWIDTH  number of words to transfer.
- wr_data  in  DWIDTH  write-data stream.
- wr_valid  in  1  write data offered.
- wr_ready  out  1  write data consumed.
- rd_data  out  DWIDTH  read-data stream.
- rd_valid  out  1  read data offered.
- rd_ready  in  1  read data consumed.
- seg_addr  out  AWIDTH  request address token.
- seg_dataW  out  DWIDTH  request write-data token.
- seg_write  out  1  request write flag token.
- seg_req_valid  out  1  request token valid.
- seg_req_ready  in  1  segment accepts request.
- seg_dataR  in  DWIDTH  segment read-response token.
- seg_rsp_valid  in  1  response valid.
- seg_rsp_ready  out  1  response consumed.
- done  out  1  one-cycle pulse at transfer completion.
- err  out  1  sticky until next accepted command: last command was rejected for a bad base.

Behaviour:
- Reset (asynchronous, active-high). Forces:
  - state IDLE; addr, count and outstanding counters to 0.
  - done=0, err=0, cmd_ready=1, seg_req_valid=0, wr_ready=0.
  - rd_valid follows seg_rsp_valid, which is gated to 0 while reset is high.
  - Reset mid-transfer abandons the transfer, and in-flight responses are not counted. The integrating environment resets the segment in the same event.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - cmd_ready=1. On cmd_valid, latch base, len and write.
  - cmd_base >= NELEMS: set err=1, pulse done next cycle, stay IDLE, issue no requests.
  - cmd_len == 0: err=0, pulse done next cycle, stay IDLE.
  - Otherwise: err=0, go to ISSUE with addr=base and remaining=len.
- ISSUE, write direction:
  - seg_req_valid = wr_valid; seg_write=1; seg_addr=addr; seg_dataW=wr_data.
  - wr_ready = seg_req_ready. Neither stream is consumed without the other (zero-latency pass-through, no buffering).
  - On each handshake: addr advances, remaining decrements.
  - After the last handshake, pulse done on the next cycle and go to IDLE.
- ISSUE, read direction:
  - seg_req_valid = (outstanding < MAX_OUT); seg_write=0; seg_dataW=0.
  - On each handshake: addr advances, remaining decrements, outstanding increments.
  - After the last issue, go to DRAIN.
- Response path (both ISSUE and DRAIN):
  - rd_data = seg_dataR, rd_valid = seg_rsp_valid, seg_rsp_ready = rd_ready.
  - Each response handshake decrements outstanding.
  - A request handshake and a response handshake in the same cycle leave outstanding unchanged.
- DRAIN: when outstanding reaches 0 (last response handshake), pulse done next cycle and go to IDLE.
- Address wrap: next addr = (addr == NELEMS-1) ? 0 : addr+1. The AWIDTH-bit counter never exceeds NELEMS-1.
- cmd_ready=0 outside IDLE. Commands are never queued.
- Responses arriving in IDLE are not accepted: seg_rsp_ready=0 in IDLE.
- Latency:
  - First request is valid the cycle after command acceptance.
  - Steady-state throughput is one word per cycle when all handshakes are ready.
  - done is registered, one cycle after the final event.

Test Plan:
- Write burst: base=5, len=3, write=1, wr_data 0xA,0xB,0xC, seg_req_ready=1 -> seg_addr 5,6,7 with seg_write=1 and dataW 0xA..0xC on consecutive cycles; done one cycle after the third handshake.
- Read with backpressure: base=0, len=8, MAX_OUT=4, responses withheld -> exactly 4 requests (addr 0..3), then seg_req_valid=0. Releasing responses resumes issue. Eight rd tokens appear in order; done follows the 8th rd handshake.
- Wrap: base=125, len=4, NELEMS=127 -> addresses 125,126,0,1.
- Edge commands:
  - len=0 -> no seg_req_valid; done pulses one cycle after acceptance; err=0.
  - base=127 -> done pulses, err=1.
  - A following valid command clears err.
- Simultaneous events: read with request and response handshakes on the same cycle -> outstanding count unchanged, never exceeds MAX_OUT (bench assertion).
- Reset mid-read: assert reset with 3 reads outstanding -> outputs return to reset values immediately; a next command base=10, len=1 issues addr 10 and completes normally.
